// File: rtl/dnlink_pkg.sv
// Shared definitions for the downlink PCM receiver: frame layout, FSM states, parity helper.
package dnlink_pkg;

    localparam int unsigned WORD_W     = 15;
    localparam int unsigned FRAME_BITS = 33;

    // Positions in the capture register once all bits are shifted in, MSB first.
    localparam int unsigned ORDER_POS = 32;
    localparam int unsigned W1_MSB    = 31;
    localparam int unsigned W1_LSB    = 17;
    localparam int unsigned P1_POS    = 16;
    localparam int unsigned W2_MSB    = 15;
    localparam int unsigned W2_LSB    = 1;
    localparam int unsigned P2_POS    = 0;

    typedef enum logic [2:0] {IDLE, GAP, BIT, ENDP, LOAD} state_e;

    // 1 when 15 data bits plus parity do not hold an odd number of ones.
    function automatic logic odd_par_fail(input logic [WORD_W-1:0] data, input logic par);
        return ~(^data ^ par);
    endfunction

endpackage

// File: rtl/dnlink_bit_timer.sv
// Per-bit timing for the downlink receiver: BIT_PERIOD down-counter plus bit index.
module dnlink_bit_timer #(
    parameter int unsigned BIT_PERIOD = 20,
    parameter int unsigned SAMPLE_OFS = 10,
    parameter int unsigned NBITS      = 33
) (
    input  logic CLOCK,
    input  logic rst_,
    input  logic start,
    input  logic run,
    output logic bit_start,
    output logic sample_strobe,
    output logic last_bit
);
    localparam int unsigned CW = $clog2(BIT_PERIOD);
    localparam int unsigned IW = $clog2(NBITS);
    localparam logic [CW-1:0] CNT_TOP  = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_SMP  = CW'(BIT_PERIOD - 1 - SAMPLE_OFS);
    localparam logic [IW-1:0] IDX_LAST = IW'(NBITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (start) begin
            cnt_d = CNT_TOP;
            idx_d = '0;
        end else if (run) begin
            if (cnt_q == '0) begin
                cnt_d = CNT_TOP;
                idx_d = idx_q + IW'(1);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // The counter runs top-down, so offset k within a bit is CNT_TOP - k.
    assign bit_start     = run && (cnt_q == CNT_TOP);
    assign sample_strobe = run && (cnt_q == CNT_SMP);
    assign last_bit      = run && (cnt_q == '0) && (idx_q == IDX_LAST);

endmodule

// File: rtl/dnlink_pcm_rx.sv
// PCM telemetry receiver for the AGC digital downlink: paces frames with DKSTRT/DKBSNC/END
// and captures parity-checked 33-bit frames behind a valid/ack handshake.
module dnlink_pcm_rx
    import dnlink_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD = 20480,
    parameter int unsigned BIT_PERIOD   = 20,
    parameter int unsigned SAMPLE_OFS   = 10,
    parameter int unsigned NBITS        = 33
) (
    input  logic              CLOCK,
    input  logic              rst_,
    input  logic              enable,
    input  logic              DKDATA,
    input  logic              DKDATB,
    output logic              DKSTRT,
    output logic              DKBSNC,
    output logic              END,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              order_bit,
    output logic [WORD_W-1:0] word1,
    output logic [WORD_W-1:0] word2,
    output logic [1:0]        par_err,
    output logic              line_err,
    output logic              overrun
);
    localparam int unsigned TW = $clog2(FRAME_PERIOD);
    localparam logic [TW-1:0] TMR_LAST = TW'(FRAME_PERIOD - 1);

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  en_q;
    logic [FRAME_BITS-1:0] sr_q;
    logic                  lerr_acc_q;
    logic                  bit_start, sample_strobe, last_bit;
    logic                  valid_q, order_q, lerr_q, ovr_q;
    logic [WORD_W-1:0]     w1_q, w2_q;
    logic [1:0]            perr_q;

    // Registered enable keeps DKSTRT low while reset is held; the timer sits at 0 until it rises.
    always_comb begin
        timer_d = '0;
        if (en_q && (timer_q != TMR_LAST)) timer_d = timer_q + TW'(1);
    end

    always_comb begin
        state_d = state_q;
        DKSTRT  = 1'b0;
        END     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_q && (timer_q == '0)) begin
                    DKSTRT  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP:  state_d = BIT;
            BIT:  if (last_bit) state_d = ENDP;
            ENDP: begin
                END     = 1'b1;
                state_d = LOAD;
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            timer_q <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            en_q    <= enable;
        end
    end

    dnlink_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD),
        .SAMPLE_OFS (SAMPLE_OFS),
        .NBITS      (NBITS)
    ) u_bit_timer (
        .CLOCK         (CLOCK),
        .rst_          (rst_),
        .start         (state_q == GAP),
        .run           (state_q == BIT),
        .bit_start     (bit_start),
        .sample_strobe (sample_strobe),
        .last_bit      (last_bit)
    );

    assign DKBSNC = bit_start;

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            sr_q       <= '0;
            lerr_acc_q <= 1'b0;
        end else if (state_q == GAP) begin
            sr_q       <= '0;
            lerr_acc_q <= 1'b0;
        end else if (sample_strobe) begin
            sr_q       <= {sr_q[FRAME_BITS-2:0], DKDATA};
            lerr_acc_q <= lerr_acc_q | (DKDATA == DKDATB);
        end
    end

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            valid_q <= 1'b0;
            order_q <= 1'b0;
            w1_q    <= '0;
            w2_q    <= '0;
            perr_q  <= '0;
            lerr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (state_q == LOAD) begin
            valid_q <= 1'b1;
            order_q <= sr_q[ORDER_POS];
            w1_q    <= sr_q[W1_MSB:W1_LSB];
            w2_q    <= sr_q[W2_MSB:W2_LSB];
            perr_q  <= {odd_par_fail(sr_q[W2_MSB:W2_LSB], sr_q[P2_POS]),
                        odd_par_fail(sr_q[W1_MSB:W1_LSB], sr_q[P1_POS])};
            lerr_q  <= lerr_acc_q;
            // An ack landing with LOAD consumes the old frame, so it is not an overrun.
            if (valid_q && !frame_ack) ovr_q <= 1'b1;
        end else if (valid_q && frame_ack) begin
            valid_q <= 1'b0;
        end
    end

    assign frame_valid = valid_q;
    assign order_bit   = order_q;
    assign word1       = w1_q;
    assign word2       = w2_q;
    assign par_err     = perr_q;
    assign line_err    = lerr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_dnlink_pcm_rx.sv
// Self-checking bench for dnlink_pcm_rx: directed frame table, random frames against a
// bit-counting reference model, and handshake / reset / enable corner sequences.
module tb_dnlink_pcm_rx;
    localparam int FP      = 700;
    localparam int BP      = 20;
    localparam int SO      = 10;
    localparam int NB      = 33;
    localparam int T_END   = 2 + NB * BP;
    localparam int T_VALID = T_END + 2;

    logic        CLOCK = 1'b0;
    logic        rst_, enable, DKDATA, DKDATB, frame_ack;
    logic        DKSTRT, DKBSNC, END, frame_valid, order_bit, line_err, overrun;
    logic [14:0] word1, word2;
    logic [1:0]  par_err;

    typedef struct {
        logic        order;
        logic [14:0] w1;
        logic [14:0] w2;
        logic [1:0]  par;
        logic        line;
    } res_t;

    typedef struct {
        logic [32:0] bits;
        int          bad;
        res_t        want;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_strt = 0;
    int last_wait = 0;

    dnlink_pcm_rx #(
        .FRAME_PERIOD (FP),
        .BIT_PERIOD   (BP),
        .SAMPLE_OFS   (SO),
        .NBITS        (NB)
    ) dut (
        .CLOCK       (CLOCK),
        .rst_        (rst_),
        .enable      (enable),
        .DKDATA      (DKDATA),
        .DKDATB      (DKDATB),
        .DKSTRT      (DKSTRT),
        .DKBSNC      (DKBSNC),
        .END         (END),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .order_bit   (order_bit),
        .word1       (word1),
        .word2       (word2),
        .par_err     (par_err),
        .line_err    (line_err),
        .overrun     (overrun)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
        end
    endtask

    function automatic logic [38:0] outs();
        return {DKSTRT, DKBSNC, END, frame_valid, order_bit, word1, word2, par_err,
                line_err, overrun};
    endfunction

    // Reference: walk the wire-order bit list, rebuild words arithmetically, count ones.
    function automatic res_t model(input logic [32:0] bits, input int bad);
        res_t r;
        int   ones1, ones2, v1, v2, b;
        ones1 = 0; ones2 = 0; v1 = 0; v2 = 0;
        r.order = 1'b0;
        for (int i = 0; i < 33; i++) begin
            b = int'(bits[32 - i]);
            if (i == 0) r.order = bits[32];
            else if (i <= 15) v1 = v1 * 2 + b;
            else if (i >= 17 && i <= 31) v2 = v2 * 2 + b;
            if (i >= 1 && i <= 16) ones1 += b;
            if (i >= 17) ones2 += b;
        end
        r.w1   = 15'(v1);
        r.w2   = 15'(v2);
        r.par  = {(ones2 % 2) == 0, (ones1 % 2) == 0};
        r.line = (bad >= 0) && (bad < 33);
        return r;
    endfunction

    // ack_mode: 0 none, 1 ack after frame_valid rises, 2 ack in the LOAD clock.
    task automatic run_frame(input string tag, input logic [32:0] bits, input int bad,
                             input res_t want, input logic want_ovr, input int ack_mode,
                             input int drop_at, input bit chk_period, input logic want_fv_pre);
        int t, idx, bad_pulses, nbsnc;
        logic exp_b;
        t = 0;
        while (DKSTRT !== 1'b1 && t < 2 * FP + 4) begin
            @(negedge CLOCK);
            t++;
        end
        last_wait = t;
        chk({tag, "_dkstrt_seen"}, 64'(DKSTRT), 64'd1);
        if (chk_period) chk({tag, "_frame_period"}, 64'(cyc - last_strt), 64'(FP));
        last_strt = cyc;
        idx = 0; bad_pulses = 0; nbsnc = 0;
        for (int c = 1; c <= T_VALID + 1; c++) begin
            @(negedge CLOCK);
            if (c == drop_at) enable = 1'b0;
            exp_b = (c >= 2) && (c < 2 + NB * BP) && ((c - 2) % BP == 0);
            if (DKBSNC !== exp_b) bad_pulses++;
            if (END !== (c == T_END)) bad_pulses++;
            if (DKSTRT !== 1'b0) bad_pulses++;
            if (DKBSNC === 1'b1) begin
                nbsnc++;
                if (idx < 33) begin
                    DKDATA = bits[32 - idx];
                    DKDATB = (idx == bad) ? bits[32 - idx] : ~bits[32 - idx];
                end
                idx++;
            end
            if (c == T_VALID - 1) begin
                chk({tag, "_fv_before_load"}, 64'(frame_valid), 64'(want_fv_pre));
                if (ack_mode == 2) frame_ack = 1'b1;
            end
            if (c == T_VALID) begin
                frame_ack = 1'b0;
                chk({tag, "_fv_rise"}, 64'(frame_valid), 64'd1);
                chk({tag, "_order"}, 64'(order_bit), 64'(want.order));
                chk({tag, "_word1"}, 64'(word1), 64'(want.w1));
                chk({tag, "_word2"}, 64'(word2), 64'(want.w2));
                chk({tag, "_par_err"}, 64'(par_err), 64'(want.par));
                chk({tag, "_line_err"}, 64'(line_err), 64'(want.line));
                chk({tag, "_overrun"}, 64'(overrun), 64'(want_ovr));
                if (ack_mode == 1) frame_ack = 1'b1;
            end
            if (c == T_VALID + 1) begin
                frame_ack = 1'b0;
                chk({tag, "_fv_after"}, 64'(frame_valid), (ack_mode == 1) ? 64'd0 : 64'd1);
                if (ack_mode == 1) begin
                    chk({tag, "_word1_held"}, 64'(word1), 64'(want.w1));
                    chk({tag, "_word2_held"}, 64'(word2), 64'(want.w2));
                end
            end
        end
        chk({tag, "_pulse_timing"}, 64'(bad_pulses), 64'd0);
        chk({tag, "_bsnc_count"}, 64'(nbsnc), 64'(NB));
    endtask

    initial begin
        vec_t        tbl[4];
        logic [32:0] bits;
        int          bad, t, cnt;

        tbl[0].bits = {1'b0, 15'h5555, 1'b1, 15'h2AAA, 1'b0};
        tbl[0].bad  = -1;
        tbl[0].want = '{1'b0, 15'h5555, 15'h2AAA, 2'b00, 1'b0};
        tbl[1].bits = {1'b0, 15'h5555, 1'b0, 15'h2AAA, 1'b0};
        tbl[1].bad  = -1;
        tbl[1].want = '{1'b0, 15'h5555, 15'h2AAA, 2'b01, 1'b0};
        tbl[2].bits = {1'b0, 15'h5555, 1'b1, 15'h2AAA, 1'b0};
        tbl[2].bad  = 7;
        tbl[2].want = '{1'b0, 15'h5555, 15'h2AAA, 2'b00, 1'b1};
        tbl[3].bits = {1'b1, 15'h7FFF, 1'b0, 15'h0000, 1'b0};
        tbl[3].bad  = -1;
        tbl[3].want = '{1'b1, 15'h7FFF, 15'h0000, 2'b10, 1'b0};

        rst_ = 1'b1; enable = 1'b0; DKDATA = 1'b0; DKDATB = 1'b1; frame_ack = 1'b0;
        #1 rst_ = 1'b0;
        #1 chk("reset_outputs", 64'(outs()), 64'd0);
        repeat (3) @(negedge CLOCK);
        enable = 1'b1;
        rst_   = 1'b1;

        for (int i = 0; i < 4; i++)
            run_frame($sformatf("vec%0d", i), tbl[i].bits, tbl[i].bad, tbl[i].want, 1'b0, 1,
                      -1, i > 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            bits = {1'($urandom_range(0, 1)), 32'($urandom)};
            bad  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 32)) : -1;
            run_frame($sformatf("rnd%0d", r), bits, bad, model(bits, bad), 1'b0, 1, -1, 1,
                      1'b0);
        end

        // Handshake: unacked frame, ack on LOAD clock, then a genuine overrun.
        bits = {1'($urandom_range(0, 1)), 32'($urandom)};
        run_frame("hs_noack", bits, -1, model(bits, -1), 1'b0, 0, -1, 1, 1'b0);
        bits = {1'($urandom_range(0, 1)), 32'($urandom)};
        run_frame("hs_ackload", bits, -1, model(bits, -1), 1'b0, 2, -1, 1, 1'b1);
        bits = {1'($urandom_range(0, 1)), 32'($urandom)};
        run_frame("hs_overrun", bits, -1, model(bits, -1), 1'b1, 0, -1, 1, 1'b1);
        bits = {1'($urandom_range(0, 1)), 32'($urandom)};
        run_frame("hs_sticky", bits, 3, model(bits, 3), 1'b1, 1, -1, 1, 1'b1);

        // Reset in the middle of bit 12.
        t = 0;
        while (DKSTRT !== 1'b1 && t < 2 * FP + 4) begin
            @(negedge CLOCK);
            t++;
        end
        chk("rst_dkstrt_seen", 64'(DKSTRT), 64'd1);
        repeat (2 + 12 * BP + 5) @(negedge CLOCK);
        rst_ = 1'b0;
        #1 chk("rst_async_outputs", 64'(outs()), 64'd0);
        cnt = 0;
        repeat (4) begin
            @(negedge CLOCK);
            if (outs() !== 39'd0) cnt++;
        end
        chk("rst_held_quiet", 64'(cnt), 64'd0);
        rst_ = 1'b1;
        bits = {1'b0, 15'h1234, 1'b1, 15'h4321, 1'b1};
        run_frame("post_rst", bits, -1, model(bits, -1), 1'b0, 1, -1, 0, 1'b0);
        chk("post_rst_prompt_start", 64'(last_wait <= 2), 64'd1);

        // enable dropped mid-frame: frame completes, then no further DKSTRT.
        bits = {1'($urandom_range(0, 1)), 32'($urandom)};
        run_frame("en_drop", bits, -1, model(bits, -1), 1'b0, 1, 100, 1, 1'b0);
        cnt = 0;
        repeat (2 * FP) begin
            @(negedge CLOCK);
            if (DKSTRT !== 1'b0) cnt++;
        end
        chk("en_drop_no_dkstrt", 64'(cnt), 64'd0);
        enable = 1'b1;
        bits = {1'($urandom_range(0, 1)), 32'($urandom)};
        run_frame("en_resume", bits, -1, model(bits, -1), 1'b0, 1, -1, 0, 1'b0);
        chk("en_resume_prompt_start", 64'(last_wait <= 2), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
